// File: rtl/inert_pkg.sv
// inert_pkg: shared state encoding, default parameters and deadband helper for the multi-axis integrator
package inert_pkg;
  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
  localparam int NUM_AXES_D = 3;
  localparam int RATE_W_D = 16;
  localparam int CAL_LOG2_D = 11;
  localparam int ACC_W_D = 27;
  localparam int OUT_W_D = 12;
  localparam int DEADBAND_D = 8;
  function automatic logic deadband_zero(input logic signed [31:0] comp, input int db);
    return ((comp < 0) ? -comp : comp) < db;
  endfunction
endpackage

// File: rtl/inert_axis_chan.sv
// inert_axis_chan: per-axis calibration sum, zero-rate offset and wrapping heading accumulator
module inert_axis_chan
  import inert_pkg::*;
#(
  parameter int RATE_W = RATE_W_D,
  parameter int CAL_LOG2 = CAL_LOG2_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int DEADBAND = DEADBAND_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_cal_acc,
  input  logic              i_cal_latch,
  input  logic              i_run_acc,
  input  logic [RATE_W-1:0] i_rate,
  output logic [OUT_W-1:0]  o_heading
);
  localparam int SUM_W = RATE_W + CAL_LOG2;
  logic [SUM_W-1:0]  r_sum;
  logic [RATE_W-1:0] r_off;
  logic [ACC_W-1:0]  r_acc;
  logic [SUM_W-1:0]  w_sum_nxt;
  logic [RATE_W:0]   w_comp;
  logic [RATE_W:0]   w_dz;
  logic [31:0]       w_comp32;
  logic [ACC_W-1:0]  w_ext;
  assign w_sum_nxt = r_sum + {{CAL_LOG2{i_rate[RATE_W-1]}}, i_rate};
  assign w_comp = {i_rate[RATE_W-1], i_rate} - {r_off[RATE_W-1], r_off};
  assign w_comp32 = {{(31-RATE_W){w_comp[RATE_W]}}, w_comp};
  assign w_dz = deadband_zero(w_comp32, DEADBAND) ? '0 : w_comp;
  assign w_ext = {{(ACC_W-RATE_W-1){w_dz[RATE_W]}}, w_dz};
  assign o_heading = r_acc[ACC_W-1 -: OUT_W];
  // dropping the low CAL_LOG2 bits of the signed sum is the floor average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_off <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
      r_acc <= '0;
    end else begin
      if (i_cal_acc) r_sum <= w_sum_nxt;
      if (i_cal_latch) r_off <= w_sum_nxt[SUM_W-1:CAL_LOG2];
      if (i_run_acc) r_acc <= r_acc + w_ext;
    end
  end
endmodule

// File: rtl/inert_multi_integrator.sv
// inert_multi_integrator: calibrates and integrates NUM_AXES angular-rate channels into wrapping headings
module inert_multi_integrator
  import inert_pkg::*;
#(
  parameter int NUM_AXES = NUM_AXES_D,
  parameter int RATE_W = RATE_W_D,
  parameter int CAL_LOG2 = CAL_LOG2_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int DEADBAND = DEADBAND_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       strt_cal,
  input  logic                       vld,
  input  logic [NUM_AXES*RATE_W-1:0] rate,
  input  logic                       moving,
  output logic                       cal_done,
  output logic                       rdy,
  output logic [NUM_AXES*OUT_W-1:0]  heading
);
  state_t r_state, w_state_nxt;
  logic [CAL_LOG2-1:0] r_cnt;
  logic r_cal_done, r_rdy;
  logic w_cal_acc, w_last, w_run;
  always_comb begin
    w_cal_acc = (r_state == CAL) && vld && !strt_cal;
    w_last = w_cal_acc && (r_cnt == '1);
    w_run = (r_state == RUN) && vld && !strt_cal;
    w_state_nxt = strt_cal ? CAL : w_last ? RUN : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // counter wraps back to zero on the final calibration sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_cal_done <= 1'b0;
      r_rdy <= 1'b0;
    end else begin
      r_cnt <= strt_cal ? '0 : w_cal_acc ? r_cnt + CAL_LOG2'(1) : r_cnt;
      r_cal_done <= w_last;
      r_rdy <= w_run;
    end
  end
  assign cal_done = r_cal_done;
  assign rdy = r_rdy;
  for (genvar k = 0; k < NUM_AXES; k++) begin : g_ax
    inert_axis_chan #(
      .RATE_W(RATE_W), .CAL_LOG2(CAL_LOG2), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEADBAND(DEADBAND)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .i_clr(strt_cal),
      .i_cal_acc(w_cal_acc),
      .i_cal_latch(w_last),
      .i_run_acc(w_run && moving),
      .i_rate(rate[k*RATE_W +: RATE_W]),
      .o_heading(heading[k*OUT_W +: OUT_W])
    );
  end
endmodule

// File: tb/tb_inert_multi_integrator.sv
// tb_inert_multi_integrator: directed plus randomized checks against an arithmetic reference model
module tb_inert_multi_integrator;
  localparam int CL = 4;
  localparam longint M = 64'd1 << 27;
  logic clk = 1'b0, rst_n = 1'b0, strt_cal = 1'b0, vld = 1'b0, moving = 1'b0;
  logic [47:0] rate = '0;
  logic cal_done, rdy;
  logic [35:0] heading;
  int n_cmp = 0, n_err = 0;
  int m_mode = 0, m_cnt = 0;
  longint m_sum[3], m_off[3], m_acc[3];
  logic m_rdy = 1'b0, m_cd = 1'b0;
  inert_multi_integrator #(.CAL_LOG2(CL)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .rate(rate),
    .moving(moving), .cal_done(cal_done), .rdy(rdy), .heading(heading)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_rdy = 0; m_cd = 0;
    for (int a = 0; a < 3; a++) begin m_sum[a] = 0; m_off[a] = 0; m_acc[a] = 0; end
  endtask
  function automatic logic [35:0] exp_head();
    return {m_acc[2][26:15], m_acc[1][26:15], m_acc[0][26:15]};
  endfunction
  task automatic step(input logic s, input logic v, input logic mv,
                      input logic signed [15:0] r0, input logic signed [15:0] r1, input logic signed [15:0] r2);
    longint r[3];
    longint c;
    r[0] = r0; r[1] = r1; r[2] = r2;
    @(negedge clk);
    strt_cal = s; vld = v; moving = mv; rate = {r2, r1, r0};
    @(posedge clk);
    m_rdy = 0; m_cd = 0;
    if (s) begin
      m_mode = 1; m_cnt = 0;
      for (int a = 0; a < 3; a++) begin m_sum[a] = 0; m_acc[a] = 0; end
    end else if (v && m_mode == 1) begin
      m_cnt++;
      for (int a = 0; a < 3; a++) m_sum[a] += r[a];
      if (m_cnt == (1 << CL)) begin
        for (int a = 0; a < 3; a++) m_off[a] = m_sum[a] >>> CL;
        m_mode = 2; m_cd = 1;
      end
    end else if (v && m_mode == 2) begin
      m_rdy = 1;
      for (int a = 0; a < 3; a++) begin
        c = r[a] - m_off[a];
        if (c > -8 && c < 8) c = 0;
        if (mv) m_acc[a] = (((m_acc[a] + c) % M) + M) % M;
      end
    end
    #1;
    chk("rdy", 64'(rdy), 64'(m_rdy));
    chk("cal_done", 64'(cal_done), 64'(m_cd));
    chk("heading", 64'(heading), 64'(exp_head()));
    chk("acc0", 64'(dut.g_ax[0].u_chan.r_acc), 64'(m_acc[0]));
  endtask
  initial begin
    bit seen_fff;
    model_reset();
    #12 rst_n = 1'b1;
    chk("reset_heading", 64'(heading), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'sd500, 16'sd20, -16'sd9);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'sd100, -16'sd37, 16'sd0);
    chk("off1", 64'(dut.g_ax[1].u_chan.r_off), 64'(16'hFFDB));
    for (int i = 0; i < 1024; i++) step(0, 1, 1, 16'sd164, -16'sd37, 16'sd0);
    chk("acc0_65536", 64'(dut.g_ax[0].u_chan.r_acc), 64'd65536);
    chk("heading_2", 64'(heading), 64'd2);
    step(0, 1, 1, 16'sd107, -16'sd37, 16'sd0);
    chk("db_7", 64'(dut.g_ax[0].u_chan.r_acc), 64'd65536);
    step(0, 1, 1, 16'sd108, -16'sd37, 16'sd0);
    chk("db_8", 64'(dut.g_ax[0].u_chan.r_acc), 64'd65544);
    step(0, 1, 1, 16'sd92, -16'sd44, 16'sd8);
    step(0, 1, 0, 16'sd36, -16'sd37, 16'sd0);
    chk("hold", 64'(dut.g_ax[0].u_chan.r_acc), 64'(m_acc[0]));
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'sd0, 16'sd0, 16'sd0);
    seen_fff = 0;
    for (int i = 0; i < 4097; i++) begin
      step(0, 1, 1, 16'sd32767, 16'sd0, 16'sd0);
      if (heading[11:0] == 12'hFFF) seen_fff = 1;
    end
    chk("wrap_fff_seen", 64'(seen_fff), 64'd1);
    chk("wrap_acc", 64'(dut.g_ax[0].u_chan.r_acc), 64'd28671);
    chk("wrap_head", 64'(heading[11:0]), 64'd0);
    step(1, 1, 1, 16'sd32767, 16'sd0, 16'sd0);
    chk("recal_rdy", 64'(rdy), 64'd0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 16'sd50 + 16'(i), -16'sd20, 16'sd10);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 16'sd1000, -16'sd900, 16'sd0);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_rdy", 64'(rdy), 64'd0);
    chk("arst_cd", 64'(cal_done), 64'd0);
    chk("arst_heading", 64'(heading), 64'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 1, 16'sd300, 16'sd300, 16'sd300);
    for (int i = 0; i < 600; i++) begin
      logic signed [15:0] rr[3];
      for (int a = 0; a < 3; a++)
        rr[a] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 80)) - 40 + a * 500);
      step(i == 0 || $urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rr[0], rr[1], rr[2]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
